// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone pipelined initiator: takes one command at a time,
// runs it with retry and timeout handling, and returns one response.
module wb_initiator #(
   parameter int unsigned g_timeout   = 255,
   parameter int unsigned g_max_retry = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_we_i,
   input  logic [31:0] cmd_adr_i,
   input  logic [31:0] cmd_dat_i,
   input  logic [3:0]  cmd_sel_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_dat_o,
   output logic        rsp_err_o,
   output logic        rsp_tmo_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   input  logic        wb_rty_i,
   input  logic        wb_stall_i,
   input  logic [31:0] wb_dat_i
);

   localparam int unsigned TMO_W = 16;
   localparam int unsigned RTY_W = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_STROBE,
      S_WAIT,
      S_GAP,
      S_RESP
   } state_t;

   state_t             r_state;
   logic [TMO_W-1:0]   r_tmo_cnt;
   logic [RTY_W-1:0]   r_retry;

   logic w_tmo_exp;
   logic w_rty_ok;
   logic w_any_term;
   logic w_ack_only;

   assign w_tmo_exp  = (r_tmo_cnt == TMO_W'(g_timeout - 1));
   assign w_rty_ok   = (r_retry < RTY_W'(g_max_retry));
   assign w_any_term = wb_err_i | wb_rty_i | wb_ack_i;
   assign w_ack_only = wb_ack_i & ~wb_err_i & ~wb_rty_i;

   // Command fields live directly in the wb_* output registers for the whole transfer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_tmo_cnt   <= '0;
         r_retry     <= '0;
         cmd_ready_o <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_dat_o   <= '0;
         rsp_err_o   <= 1'b0;
         rsp_tmo_o   <= 1'b0;
         wb_cyc_o    <= 1'b0;
         wb_stb_o    <= 1'b0;
         wb_we_o     <= 1'b0;
         wb_adr_o    <= '0;
         wb_dat_o    <= '0;
         wb_sel_o    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               cmd_ready_o <= 1'b1;
               if (cmd_valid_i && cmd_ready_o) begin
                  cmd_ready_o <= 1'b0;
                  wb_we_o     <= cmd_we_i;
                  wb_adr_o    <= cmd_adr_i;
                  wb_dat_o    <= cmd_dat_i;
                  wb_sel_o    <= cmd_sel_i;
                  r_retry     <= '0;
                  r_tmo_cnt   <= '0;
                  wb_cyc_o    <= 1'b1;
                  wb_stb_o    <= 1'b1;
                  r_state     <= S_STROBE;
               end
            end

            // Terminations are not sampled here; only stall and timeout matter.
            S_STROBE: begin
               if (w_tmo_exp) begin
                  wb_cyc_o    <= 1'b0;
                  wb_stb_o    <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  rsp_dat_o   <= '0;
                  rsp_err_o   <= 1'b1;
                  rsp_tmo_o   <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
                  if (!wb_stall_i) begin
                     wb_stb_o <= 1'b0;
                     r_state  <= S_WAIT;
                  end
               end
            end

            S_WAIT: begin
               if (wb_rty_i && !wb_err_i && w_rty_ok) begin
                  r_retry  <= r_retry + 1'b1;
                  wb_cyc_o <= 1'b0;
                  r_state  <= S_GAP;
               end else if (w_any_term || w_tmo_exp) begin
                  // A termination seen on the expiry cycle wins over the timeout.
                  wb_cyc_o    <= 1'b0;
                  wb_stb_o    <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  rsp_dat_o   <= (w_ack_only && !wb_we_o) ? wb_dat_i : '0;
                  rsp_err_o   <= ~w_ack_only;
                  rsp_tmo_o   <= ~w_any_term;
                  r_state     <= S_RESP;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
            end

            S_GAP: begin
               r_tmo_cnt <= '0;
               wb_cyc_o  <= 1'b1;
               wb_stb_o  <= 1'b1;
               r_state   <= S_STROBE;
            end

            S_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  cmd_ready_o <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator: read/write, stall, retry, timeout,
// termination priority, response back-pressure and mid-transfer reset.
module tb_wb_initiator;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [31:0] cmd_adr;
   logic [31:0] cmd_dat;
   logic [3:0]  cmd_sel;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic        rsp_tmo;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_we;
   logic [31:0] wb_adr;
   logic [31:0] wb_dat_m;
   logic [3:0]  wb_sel;
   logic        wb_ack;
   logic        wb_err;
   logic        wb_rty;
   logic        wb_stall;
   logic [31:0] wb_dat_s;

   int n_checks = 0;
   int n_errors = 0;

   wb_initiator #(
      .g_timeout   (8),
      .g_max_retry (3)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_we_i    (cmd_we),
      .cmd_adr_i   (cmd_adr),
      .cmd_dat_i   (cmd_dat),
      .cmd_sel_i   (cmd_sel),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_dat_o   (rsp_dat),
      .rsp_err_o   (rsp_err),
      .rsp_tmo_o   (rsp_tmo),
      .wb_cyc_o    (wb_cyc),
      .wb_stb_o    (wb_stb),
      .wb_we_o     (wb_we),
      .wb_adr_o    (wb_adr),
      .wb_dat_o    (wb_dat_m),
      .wb_sel_o    (wb_sel),
      .wb_ack_i    (wb_ack),
      .wb_err_i    (wb_err),
      .wb_rty_i    (wb_rty),
      .wb_stall_i  (wb_stall),
      .wb_dat_i    (wb_dat_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Presents a command and returns on the falling edge after the handshake edge.
   task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
      int n;
      n = 0;
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_dat   = dat;
      cmd_sel   = sel;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("hs_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic consume(input string tag);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_eq({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
      check_eq({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
      rsp_ready = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0; wb_stall = 1'b0;
      wb_dat_s = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("rst_cyc", 32'(wb_cyc), 32'd0);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_adr", wb_adr, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rel_cmd_ready", 32'(cmd_ready), 32'd1);

      // Read, no stall, ack on first WAIT cycle
      issue(1'b0, 32'h4, 32'h0, 4'hF);
      check_eq("rd_stb", 32'(wb_stb), 32'd1);
      check_eq("rd_cyc", 32'(wb_cyc), 32'd1);
      check_eq("rd_adr", wb_adr, 32'h4);
      check_eq("rd_we", 32'(wb_we), 32'd0);
      check_eq("rd_busy_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      check_eq("rd_stb_one", 32'(wb_stb), 32'd0);
      check_eq("rd_wait_cyc", 32'(wb_cyc), 32'd1);
      check_eq("rd_early_rsp", 32'(rsp_valid), 32'd0);
      wb_ack = 1'b1; wb_dat_s = 32'hCAFE0001;
      @(negedge clk);
      wb_ack = 1'b0;
      check_eq("rd_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("rd_rsp_dat", rsp_dat, 32'hCAFE0001);
      check_eq("rd_rsp_err", 32'(rsp_err), 32'd0);
      check_eq("rd_cyc_drop", 32'(wb_cyc), 32'd0);
      consume("rd");

      // Write with 4 stall cycles; an ack during STROBE must be ignored
      wb_stall = 1'b1; wb_dat_s = 32'hDEADBEEF;
      issue(1'b1, 32'h10, 32'h12345678, 4'hF);
      for (int i = 0; i < 5; i++) begin
         check_eq($sformatf("wr_stb_%0d", i), 32'(wb_stb), 32'd1);
         check_eq($sformatf("wr_adr_%0d", i), wb_adr, 32'h10);
         check_eq($sformatf("wr_dat_%0d", i), wb_dat_m, 32'h12345678);
         if (i == 0) begin
            check_eq("wr_we", 32'(wb_we), 32'd1);
            check_eq("wr_sel", 32'(wb_sel), 32'hF);
         end
         wb_ack = (i == 1);
         if (i == 4) wb_stall = 1'b0;
         @(negedge clk);
      end
      check_eq("wr_stb_low", 32'(wb_stb), 32'd0);
      check_eq("wr_no_early_rsp", 32'(rsp_valid), 32'd0);
      wb_ack = 1'b1;
      @(negedge clk);
      wb_ack = 1'b0;
      check_eq("wr_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("wr_rsp_dat", rsp_dat, 32'd0);
      check_eq("wr_rsp_err", 32'(rsp_err), 32'd0);
      consume("wr");

      // Retry four times with max retry 3
      issue(1'b0, 32'h20, 32'h0, 4'hF);
      for (int k = 0; k < 4; k++) begin
         check_eq($sformatf("rty_stb_%0d", k), 32'(wb_stb), 32'd1);
         check_eq($sformatf("rty_adr_%0d", k), wb_adr, 32'h20);
         @(negedge clk);
         check_eq($sformatf("rty_wait_%0d", k), 32'(wb_cyc), 32'd1);
         wb_rty = 1'b1;
         @(negedge clk);
         wb_rty = 1'b0;
         if (k < 3) begin
            check_eq($sformatf("rty_gap_%0d", k), 32'(wb_cyc), 32'd0);
            check_eq($sformatf("rty_norsp_%0d", k), 32'(rsp_valid), 32'd0);
            @(negedge clk);
         end
      end
      check_eq("rty_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("rty_rsp_err", 32'(rsp_err), 32'd1);
      check_eq("rty_rsp_tmo", 32'(rsp_tmo), 32'd0);
      check_eq("rty_cyc", 32'(wb_cyc), 32'd0);
      consume("rty");

      // Timeout with no termination
      issue(1'b0, 32'h30, 32'h0, 4'hF);
      n = 0;
      while (wb_cyc && n < 20) begin
         n++;
         @(negedge clk);
      end
      check_eq("tmo_cyc_cycles", 32'(n), 32'd8);
      check_eq("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("tmo_rsp_err", 32'(rsp_err), 32'd1);
      check_eq("tmo_rsp_tmo", 32'(rsp_tmo), 32'd1);
      consume("tmo");

      // Ack on the expiry cycle beats the timeout
      issue(1'b0, 32'h34, 32'h0, 4'hF);
      repeat (7) @(negedge clk);
      check_eq("exp_cyc", 32'(wb_cyc), 32'd1);
      wb_ack = 1'b1; wb_dat_s = 32'h5555AAAA;
      @(negedge clk);
      wb_ack = 1'b0;
      check_eq("exp_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("exp_rsp_err", 32'(rsp_err), 32'd0);
      check_eq("exp_rsp_tmo", 32'(rsp_tmo), 32'd0);
      check_eq("exp_rsp_dat", rsp_dat, 32'h5555AAAA);
      consume("exp");

      // ack+err together, then response back-pressure
      issue(1'b0, 32'h40, 32'h0, 4'hF);
      @(negedge clk);
      wb_ack = 1'b1; wb_err = 1'b1; wb_dat_s = 32'hFFFF0000;
      @(negedge clk);
      wb_ack = 1'b0; wb_err = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_eq($sformatf("bp_valid_%0d", i), 32'(rsp_valid), 32'd1);
         check_eq($sformatf("bp_err_%0d", i), 32'(rsp_err), 32'd1);
         check_eq($sformatf("bp_dat_%0d", i), rsp_dat, 32'd0);
         check_eq($sformatf("bp_ready_%0d", i), 32'(cmd_ready), 32'd0);
         @(negedge clk);
      end
      consume("bp");

      // Reset during WAIT drops the bus immediately and discards the transfer
      issue(1'b0, 32'h50, 32'h0, 4'hF);
      @(negedge clk);
      check_eq("mr_wait_cyc", 32'(wb_cyc), 32'd1);
      rst = 1'b1;
      #1;
      check_eq("mr_cyc_async", 32'(wb_cyc), 32'd0);
      check_eq("mr_stb_async", 32'(wb_stb), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("mr_ready", 32'(cmd_ready), 32'd1);
      check_eq("mr_no_rsp", 32'(rsp_valid), 32'd0);
      issue(1'b0, 32'h60, 32'h0, 4'hF);
      check_eq("mr2_adr", wb_adr, 32'h60);
      @(negedge clk);
      wb_ack = 1'b1; wb_dat_s = 32'h0000600D;
      @(negedge clk);
      wb_ack = 1'b0;
      check_eq("mr2_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("mr2_rsp_dat", rsp_dat, 32'h0000600D);
      check_eq("mr2_rsp_err", 32'(rsp_err), 32'd0);
      consume("mr2");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
